// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - request/grant signal bundle between bus masters and the arbiter
interface ahb_arbiter_if;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [2:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    // Bus side: masters drive requests and transfer info, observe grants
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    // Arbiter side
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - three-master round-robin AHB arbiter with burst and lock hold
module ahb_arbiter #(
    parameter int unsigned DEF_MASTER = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    ahb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB, BURST, LOCKED} mode_t;

    localparam logic [1:0] DEF_IDX   = 2'(DEF_MASTER);
    localparam logic [2:0] DEF_GRANT = 3'(1 << DEF_MASTER);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic [2:0] grant_q, grant_d;
    logic [1:0] master_q, master_d;
    logic       mastlock_q, mastlock_d;
    logic [1:0] rr_ptr, rr_d;
    logic [3:0] cnt, cnt_d;
    mode_t      mode, mode_d;

    logic [1:0] gidx;
    logic [3:0] load;
    logic [3:0] cnt_nxt;
    logic       arb_pt;
    logic       win_valid;
    logic [1:0] win_idx;
    logic [1:0] cand1, cand2;
    logic [1:0] new_idx;

    // State register; reset lands on the default master in arbitration mode
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q    <= DEF_GRANT;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
            rr_ptr     <= DEF_IDX;
            cnt        <= 4'd0;
            mode       <= ARB;
        end else begin
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            rr_ptr     <= rr_d;
            cnt        <= cnt_d;
            mode       <= mode_d;
        end
    end

    // Beat counting, round-robin search and grant/ownership next state
    always_comb begin
        gidx = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);

        case (bus.HBURST)
            3'b010, 3'b011: load = 4'd3;
            3'b100, 3'b101: load = 4'd7;
            3'b110, 3'b111: load = 4'd15;
            default:        load = 4'd0;
        endcase

        case (bus.HTRANS)
            T_IDLE:   cnt_nxt = 4'd0;
            T_BUSY:   cnt_nxt = cnt;
            T_NONSEQ: cnt_nxt = load;
            T_SEQ:    cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
            default:  cnt_nxt = 4'd0;
        endcase

        // Outside a lock, any edge that leaves no burst beats pending re-arbitrates;
        // this covers the last SEQ beat, aborts, SINGLE and INCR transfers.
        arb_pt = (mode == LOCKED) ? !bus.HLOCK[gidx] : (cnt_nxt == 4'd0);

        case (rr_ptr)
            2'd0:    begin cand1 = 2'd1; cand2 = 2'd2; end
            2'd1:    begin cand1 = 2'd2; cand2 = 2'd0; end
            default: begin cand1 = 2'd0; cand2 = 2'd1; end
        endcase

        win_valid = 1'b1;
        if (bus.HBUSREQ[cand1])       win_idx = cand1;
        else if (bus.HBUSREQ[cand2])  win_idx = cand2;
        else if (bus.HBUSREQ[rr_ptr]) win_idx = rr_ptr;
        else begin
            win_idx   = DEF_IDX;
            win_valid = 1'b0;
        end

        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        rr_d       = rr_ptr;
        cnt_d      = cnt;
        mode_d     = mode;
        new_idx    = gidx;

        if (bus.HREADY) begin
            master_d   = gidx;
            mastlock_d = bus.HLOCK[gidx];
            cnt_d      = cnt_nxt;
            if (arb_pt) begin
                new_idx = win_idx;
                grant_d = 3'b001 << win_idx;
                if (win_valid) rr_d = win_idx;
                if (bus.HLOCK[new_idx])      mode_d = LOCKED;
                else if (cnt_nxt != 4'd0)    mode_d = BURST;
                else                         mode_d = ARB;
            end else begin
                mode_d = (mode == LOCKED) ? LOCKED : BURST;
            end
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for the three-master AHB arbiter
module tb_ahb_arbiter;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;

    typedef struct packed {
        logic [2:0] g;
        logic [1:0] m;
        logic       l;
    } exp_t;

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] lk;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        exp_t       e;
    } row_t;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;
    row_t stim_q[$];
    exp_t exp_q[$];
    exp_t e;

    ahb_arbiter_if bus();

    ahb_arbiter #(.DEF_MASTER(0)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic add(input logic [2:0] req, input logic [2:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy,
                       input logic [2:0] g, input logic [1:0] m, input logic l);
        row_t r;
        r.req = req; r.lk = lk; r.tr = tr; r.bu = bu; r.rdy = rdy;
        r.e.g = g; r.e.m = m; r.e.l = l;
        stim_q.push_back(r);
    endtask

    // Drive one queued row, record its expectation, and sample 1 ns past the edge
    task automatic apply_row();
        row_t r;
        r = stim_q.pop_front();
        bus.HBUSREQ = r.req;
        bus.HLOCK   = r.lk;
        bus.HTRANS  = r.tr;
        bus.HBURST  = r.bu;
        bus.HREADY  = r.rdy;
        exp_q.push_back(r.e);
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_reset();
        bus.HBUSREQ = 3'b000;
        bus.HLOCK   = 3'b000;
        bus.HTRANS  = IDLE;
        bus.HBURST  = 3'b000;
        bus.HREADY  = 1'b1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        exp_q.push_back('{g: 3'b001, m: 2'd0, l: 1'b0});
        e = exp_q.pop_front();
        checks++;
        if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
            errors++;
            $display("FAIL reset got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                     bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        add(3'b111, 3'b000, NS, 3'b000, 1'b1, 3'b010, 2'd0, 1'b0);
        add(3'b111, 3'b000, NS, 3'b000, 1'b1, 3'b100, 2'd1, 1'b0);
        add(3'b111, 3'b000, NS, 3'b000, 1'b1, 3'b001, 2'd2, 1'b0);
        add(3'b111, 3'b000, NS, 3'b000, 1'b1, 3'b010, 2'd0, 1'b0);
        add(3'b111, 3'b000, NS, 3'b000, 1'b1, 3'b100, 2'd1, 1'b0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_row();
            e = exp_q.pop_front();
            checks++;
            if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
                errors++;
                $display("FAIL round_robin[%0d] got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                         i, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
            end
        end
    endtask

    // Reset asserted between edges must take effect without a clock
    task automatic test_async_reset();
        #3;
        HRESET = 1'b1;
        exp_q.push_back('{g: 3'b001, m: 2'd0, l: 1'b0});
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
            errors++;
            $display("FAIL async_reset got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                     bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
        end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic test_incr4_hold();
        apply_reset();
        add(3'b010, 3'b000, IDLE, 3'b000, 1'b1, 3'b010, 2'd0, 1'b0);
        add(3'b101, 3'b000, NS,   3'b011, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b101, 3'b000, SEQ,  3'b011, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b101, 3'b000, SEQ,  3'b011, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b101, 3'b000, SEQ,  3'b011, 1'b1, 3'b100, 2'd1, 1'b0);
        add(3'b000, 3'b000, IDLE, 3'b000, 1'b1, 3'b001, 2'd2, 1'b0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_row();
            e = exp_q.pop_front();
            checks++;
            if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
                errors++;
                $display("FAIL incr4_hold[%0d] got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                         i, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        add(3'b010, 3'b000, IDLE, 3'b000, 1'b1, 3'b010, 2'd0, 1'b0);
        add(3'b000, 3'b000, NS,   3'b011, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b000, 3'b000, SEQ,  3'b011, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b111, 3'b010, SEQ,  3'b011, 1'b0, 3'b010, 2'd1, 1'b0);
        add(3'b100, 3'b010, SEQ,  3'b011, 1'b0, 3'b010, 2'd1, 1'b0);
        add(3'b001, 3'b010, IDLE, 3'b011, 1'b0, 3'b010, 2'd1, 1'b0);
        add(3'b100, 3'b000, SEQ,  3'b011, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b100, 3'b000, SEQ,  3'b011, 1'b1, 3'b100, 2'd1, 1'b0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_row();
            e = exp_q.pop_front();
            checks++;
            if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
                errors++;
                $display("FAIL stall[%0d] got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                         i, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_lock();
        apply_reset();
        add(3'b100, 3'b100, IDLE, 3'b000, 1'b1, 3'b100, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++)
            add(3'b111, 3'b100, NS, 3'b000, 1'b1, 3'b100, 2'd2, 1'b1);
        add(3'b111, 3'b000, NS,   3'b000, 1'b1, 3'b001, 2'd2, 1'b0);
        add(3'b000, 3'b000, IDLE, 3'b000, 1'b1, 3'b001, 2'd0, 1'b0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_row();
            e = exp_q.pop_front();
            checks++;
            if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
                errors++;
                $display("FAIL lock[%0d] got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                         i, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_abort();
        apply_reset();
        add(3'b010, 3'b000, IDLE, 3'b000, 1'b1, 3'b010, 2'd0, 1'b0);
        add(3'b000, 3'b000, NS,   3'b101, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b000, 3'b000, SEQ,  3'b101, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b000, 3'b000, SEQ,  3'b101, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b000, 3'b000, IDLE, 3'b101, 1'b1, 3'b001, 2'd1, 1'b0);
        add(3'b100, 3'b000, IDLE, 3'b000, 1'b1, 3'b100, 2'd0, 1'b0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_row();
            e = exp_q.pop_front();
            checks++;
            if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
                errors++;
                $display("FAIL abort[%0d] got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                         i, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
            end
        end
    endtask

    task automatic test_incr();
        apply_reset();
        add(3'b010, 3'b000, IDLE, 3'b000, 1'b1, 3'b010, 2'd0, 1'b0);
        add(3'b011, 3'b000, NS,   3'b001, 1'b1, 3'b001, 2'd1, 1'b0);
        add(3'b011, 3'b000, SEQ,  3'b001, 1'b1, 3'b010, 2'd0, 1'b0);
        add(3'b010, 3'b000, BUSY, 3'b001, 1'b1, 3'b010, 2'd1, 1'b0);
        add(3'b010, 3'b000, SEQ,  3'b001, 1'b1, 3'b010, 2'd1, 1'b0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            apply_row();
            e = exp_q.pop_front();
            checks++;
            if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== e) begin
                errors++;
                $display("FAIL incr[%0d] got g=%b m=%0d l=%b want g=%b m=%0d l=%b",
                         i, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.g, e.m, e.l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_async_reset();
        test_incr4_hold();
        test_stall();
        test_lock();
        test_abort();
        test_incr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Three-master AHB bus arbiter that sequences ownership of the shared address/control bus ahead of the slave-to-master multiplexor. It samples bus requests, applies round-robin priority, holds ownership for fixed-length bursts and locked sequences, and drives the grant, current-master index and master-lock outputs that steer the master-side mux and the slave decode. All decisions move only on accepted transfers (HREADY high).

## Interface
- DEF_MASTER, 0, index (0..2) of the default master granted when nobody requests; also the reset owner.
- HCLK  in  1  bus clock, all state updates on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HBUSREQ  in  3  per-master bus request, bit i = master i.
- HLOCK  in  3  per-master locked-access request.
- HTRANS  in  2  transfer type of current owner's address phase (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST  in  3  burst type of current owner's address phase.
- HREADY  in  1  global transfer-done from the slave-to-master mux.
- HGRANT  out  3  one-hot grant, registered.
- HMASTER  out  2  index of the master owning the current address phase, registered.
- HMASTLOCK  out  1  current address phase is part of a locked sequence, registered.

## Operation
- Internal state: rr_ptr (2 bits, last granted index), beat counter cnt (4 bits), mode in {ARB, BURST, LOCKED}.
- Round-robin search order from rr_ptr: rr_ptr+1, rr_ptr+2, rr_ptr (mod 3). First requester wins; no request -> DEF_MASTER, rr_ptr unchanged.
- Burst load: on HREADY=1 edge with HTRANS=NONSEQ, cnt <= 3 for HBURST 010/011, 7 for 100/101, 15 for 110/111; SINGLE (000) and INCR (001) load 0. Nonzero load -> mode BURST.
- Burst count: HTRANS=SEQ with HREADY=1 decrements cnt; BUSY holds cnt; IDLE or NONSEQ while in BURST aborts (cnt cleared, NONSEQ then reloads per its HBURST).
- LOCKED: entered when HLOCK[granted index]=1 at an arbitration point; grant held while that bit stays 1; exit to ARB when it drops.
- Arbitration point: HREADY=1 edge and mode ARB, or mode BURST with cnt=1 and HTRANS=SEQ (grant changes while last beat's address is presented), and not LOCKED. Only then HGRANT/rr_ptr update.
- Ownership handover: on every HREADY=1 edge, HMASTER <= index of HGRANT, HMASTLOCK <= HLOCK[index of HGRANT].
- HGRANT always exactly one-hot; HMASTER always 0..2. Values 3 never produced.

## Timing
- Reset (async assert, any time): HGRANT = one-hot(DEF_MASTER) (001 for default), HMASTER = DEF_MASTER, HMASTLOCK = 0, cnt = 0, rr_ptr = DEF_MASTER, mode ARB. Reset mid-burst discards burst with no further effect.
- HREADY=0: no register changes at all (grant, HMASTER, counter, pointer frozen).
- Request-to-grant: 1 cycle (HBUSREQ sampled at arbitration-point edge, HGRANT valid after it).
- Grant-to-ownership: HMASTER follows HGRANT at the next HREADY=1 edge; minimum 2 cycles request to HMASTER with HREADY tied high.
- Simultaneous lock drop and new requests at an arbitration point: lock ignored (dropped), round robin applies the same edge.
- INCR (undefined length): no hold; re-arbitration every accepted beat; owner keeps grant only if it wins round robin.

## Test plan
- Reset: assert HRESET mid-cycle with DEF_MASTER=0 -> HGRANT=001, HMASTER=0, HMASTLOCK=0 immediately, without clock edge.
- Round robin: HREADY=1, HBUSREQ=111, HTRANS=NONSEQ SINGLE each cycle -> HGRANT sequence 010,100,001,010; HMASTER lags one cycle.
- INCR4 hold: master 1 granted, NONSEQ INCR4 then 3 SEQ, HBUSREQ=101 -> HGRANT stays 010 until edge accepting third SEQ, then 100.
- Stall: in burst, HREADY low 3 cycles with HBUSREQ changing -> HGRANT, HMASTER, cnt unchanged; resume continues count.
- Lock: master 2 holds HLOCK[2]=1, HBUSREQ=111 for 5 cycles -> HGRANT=100, HMASTLOCK=1 throughout; HLOCK drop -> next edge HGRANT=001.
- Abort/idle: INCR8 interrupted by IDLE after 2 beats with HBUSREQ=000 -> next edge grant to DEF_MASTER (001), mode ARB.
